// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle signed restoring divider for the div instruction.
// HI = remainder (sign of dividend), LO = quotient truncated toward zero.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0] step, diff;
  assign step = {r_q, q_q[WIDTH-1]};
  assign diff = step - {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start) begin
        // On divide-by-zero the quotient register carries the raw dividend to FIX.
        dbz_d   = B == '0;
        sq_d    = Y[WIDTH-1] ^ B[WIDTH-1];
        sr_d    = Y[WIDTH-1];
        b_d     = B[WIDTH-1] ? -B : B;
        q_d     = (B == '0) ? Y : (Y[WIDTH-1] ? -Y : Y);
        r_d     = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = (B == '0) ? FIX : RUN;
      end
      RUN: begin
        r_d   = diff[WIDTH] ? step[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? FIX : RUN;
      end
      FIX: begin
        lo_d    = dbz_q ? '1 : (sq_q ? -q_q : q_q);
        hi_d    = dbz_q ? q_q : (sr_q ? -r_q : r_q);
        dz_d    = dbz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: scoreboard bench for div_seq_unit; expected results queued at issue, checked on done.
module tb_div_seq_unit;
  logic clk = 1'b0, clr = 1'b0, start = 1'b0;
  logic [31:0] Y = '0, B = '0;
  logic busy, done, div_by_zero;
  logic [31:0] HI, LO;
  int checks = 0, failures = 0, cyc = 0, dones = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          k;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  div_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .Y(Y), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] y, input logic [31:0] b, input int k);
    exp_t m;
    logic [31:0] ay, ab, uq, ur;
    m.k = k;
    if (b == 0) begin
      m.lo = '1; m.hi = y; m.dbz = 1'b1; m.lat = 1;
    end else begin
      ay = y[31] ? -y : y;
      ab = b[31] ? -b : b;
      uq = ay / ab;
      ur = ay % ab;
      m.lo = (y[31] ^ b[31]) ? -uq : uq;
      m.hi = y[31] ? -ur : ur;
      m.dbz = 1'b0; m.lat = 33;
    end
    return m;
  endfunction
  always @(negedge clk) if (clr && done) begin
    dones++;
    chk("done_with_busy", {63'd0, busy}, 64'd0);
    if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk("LO", {32'd0, LO}, {32'd0, e.lo});
      chk("HI", {32'd0, HI}, {32'd0, e.hi});
      chk("dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
      chk("latency", 64'(cyc - e.k), 64'(e.lat));
    end
  end
  task automatic start_now(input logic [31:0] y, input logic [31:0] b, input bit track);
    Y = y; B = b; start = 1'b1;
    if (track) sb.push_back(model(y, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic issue(input logic [31:0] y, input logic [31:0] b);
    @(negedge clk);
    start_now(y, b, 1'b1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    int d0;
    logic [31:0] ry, rb;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_HI", {32'd0, HI}, 64'd0);
    chk("rst_LO", {32'd0, LO}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk) clr = 1'b1;
    issue(32'd100, 32'd7);             drain();
    issue(32'hFFFFFF9C, 32'd7);        drain();
    issue(32'd100, 32'hFFFFFFF9);      drain();
    issue(32'hFFFFFF9C, 32'hFFFFFFF9); drain();
    issue(32'd7, 32'd0);               drain();
    issue(32'd9, 32'd3);               drain();
    issue(32'h80000000, 32'hFFFFFFFF); drain();
    issue(32'h80000000, 32'h80000000); drain();
    issue(32'd5, 32'd9);               drain();
    for (int i = 0; i < 6; i++) begin
      ry = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i[0]) rb = -rb;
      if (rb == 0) rb = 1;
      issue(ry, rb); drain();
    end
    // Asynchronous reset in the middle of a divide must wipe state and suppress done.
    issue(32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_HI", {32'd0, HI}, 64'd0);
    chk("mid_rst_LO", {32'd0, LO}, 64'd0);
    sb.delete();
    d0 = dones;
    @(negedge clk) clr = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 64'(dones), 64'(d0));
    issue(32'd20, 32'd6); drain();
    // A start while busy must be ignored.
    d0 = dones;
    issue(32'd50, 32'd5);
    repeat (5) @(negedge clk);
    start_now(32'd1, 32'd1, 1'b0);
    drain();
    repeat (40) @(negedge clk);
    chk("single_done", 64'(dones), 64'(d0 + 1));
    // Back-to-back: second start coincides with the first done.
    issue(32'd1000, 32'd33);
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    chk("b2b_done_seen", {63'd0, done}, 64'd1);
    start_now(32'hFFFFF000, 32'd17, 1'b1);
    drain();
    issue(32'd0, 32'd0);               drain();
    issue(32'd77, 32'd1);              drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
